// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit:
// state encoding, opcode/funct values, ALU and next-PC select codes.
package mcpu_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R,
    C_ALU_I,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_BLTZ,
    C_J,
    C_JAL,
    C_JR,
    C_HALT,
    C_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Branch condition evaluated on the ALU flags of the compare cycle.
  function automatic logic branch_taken(input iclass_t c, input logic z, input logic s);
    case (c)
      C_BEQ:   return z;
      C_BNE:   return !z;
      C_BLTZ:  return s;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_decode.sv
// Combinational instruction decode: latched op/funct to instruction class
// and the static datapath selects that stay valid for the whole instruction.
module mcpu_decode
  import mcpu_pkg::*;
#(
  parameter int              OPW     = 6,
  parameter int              FNW     = 6,
  parameter logic [OPW-1:0]  HALT_OP = 6'b111111
) (
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  output iclass_t        iclass,
  output logic [2:0]     alu_op,
  output logic           ext_sel,
  output logic           alu_src_a,
  output logic           alu_src_b,
  output logic [1:0]     reg_dst,
  output logic           wr_reg_d_src,
  output logic           db_data_src
);

  // Class and selects from opcode; R-type further split on funct.
  always_comb begin
    iclass       = C_ILLEGAL;
    alu_op       = ALU_ADD;
    ext_sel      = 1'b1;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    reg_dst      = RD_RT;
    wr_reg_d_src = 1'b0;
    db_data_src  = 1'b0;
    if (op == HALT_OP) begin
      iclass = C_HALT;
    end else begin
      case (op)
        OPW'(OP_RTYPE): begin
          reg_dst = RD_RD;
          case (funct)
            FNW'(FN_ADD): begin iclass = C_ALU_R; alu_op = ALU_ADD; end
            FNW'(FN_SUB): begin iclass = C_ALU_R; alu_op = ALU_SUB; end
            FNW'(FN_AND): begin iclass = C_ALU_R; alu_op = ALU_AND; end
            FNW'(FN_OR):  begin iclass = C_ALU_R; alu_op = ALU_OR;  end
            FNW'(FN_SLT): begin iclass = C_ALU_R; alu_op = ALU_SLT; end
            FNW'(FN_SLL): begin
              iclass    = C_ALU_R;
              alu_op    = ALU_SLL;
              alu_src_a = 1'b1;
            end
            FNW'(FN_JR):  iclass = C_JR;
            default:      iclass = C_ILLEGAL;
          endcase
        end
        OPW'(OP_ADDIU): begin iclass = C_ALU_I; alu_op = ALU_ADD; alu_src_b = 1'b1; end
        OPW'(OP_ANDI): begin
          iclass = C_ALU_I; alu_op = ALU_AND; alu_src_b = 1'b1; ext_sel = 1'b0;
        end
        OPW'(OP_ORI): begin
          iclass = C_ALU_I; alu_op = ALU_OR; alu_src_b = 1'b1; ext_sel = 1'b0;
        end
        OPW'(OP_XORI): begin
          iclass = C_ALU_I; alu_op = ALU_XOR; alu_src_b = 1'b1; ext_sel = 1'b0;
        end
        OPW'(OP_SLTI): begin iclass = C_ALU_I; alu_op = ALU_SLT; alu_src_b = 1'b1; end
        OPW'(OP_LW): begin
          iclass      = C_LW;
          alu_op      = ALU_ADD;
          alu_src_b   = 1'b1;
          db_data_src = 1'b1;
        end
        OPW'(OP_SW):   begin iclass = C_SW;   alu_op = ALU_ADD; alu_src_b = 1'b1; end
        OPW'(OP_BEQ):  begin iclass = C_BEQ;  alu_op = ALU_SUB; end
        OPW'(OP_BNE):  begin iclass = C_BNE;  alu_op = ALU_SUB; end
        OPW'(OP_BLTZ): begin iclass = C_BLTZ; alu_op = ALU_SUB; end
        OPW'(OP_J):    iclass = C_J;
        OPW'(OP_JAL): begin
          iclass       = C_JAL;
          reg_dst      = RD_RA;
          wr_reg_d_src = 1'b1;
        end
        default: iclass = C_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// Five-phase multi-cycle control unit: sequences each instruction through
// IF/ID/EXE/MEM/WB and issues the per-state datapath strobes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IF       | fetch; IR load; op/funct latched at end of cycle
// ID       | decode; jumps (j/jal/jr) complete here
// EXE_LS   | address calculation for lw/sw
// MEM      | data memory access, held until mem_ready
// WB_LD    | load write-back, PC update
// EXE_BR   | branch compare, PC update
// EXE_AL   | ALU operation for R-type / immediate ops
// WB_AL    | ALU write-back, PC update
// (halted) | state reg parked at ID, all strobes off, exit only by reset
module multi_cycle_ctrl_fsm
  import mcpu_pkg::*;
#(
  parameter int             OPW         = 6,
  parameter int             FNW         = 6,
  parameter bit             MEM_WAIT_EN = 1'b1,
  parameter logic [OPW-1:0] HALT_OP     = 6'b111111
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  input  logic           sign,
  input  logic           mem_ready,
  output logic           PCWre,
  output logic           IRWre,
  output logic           RegWre,
  output logic           ExtSel,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic [1:0]     RegDst,
  output logic           WrRegDSrc,
  output logic           DBDataSrc,
  output logic           mRD,
  output logic           mWR,
  output logic [1:0]     PCSrc,
  output logic [2:0]     state,
  output logic           halted,
  output logic           illegal
);

  state_t         cur;
  logic           halt_q;
  logic           illegal_q;
  logic [OPW-1:0] op_q;
  logic [FNW-1:0] funct_q;
  iclass_t        iclass;
  logic           mem_done;
  logic           run;

  mcpu_decode #(
    .OPW     (OPW),
    .FNW     (FNW),
    .HALT_OP (HALT_OP)
  ) u_decode (
    .op           (op_q),
    .funct        (funct_q),
    .iclass       (iclass),
    .alu_op       (ALUOp),
    .ext_sel      (ExtSel),
    .alu_src_a    (ALUSrcA),
    .alu_src_b    (ALUSrcB),
    .reg_dst      (RegDst),
    .wr_reg_d_src (WrRegDSrc),
    .db_data_src  (DBDataSrc)
  );

  assign mem_done = !MEM_WAIT_EN || mem_ready;
  assign run      = Reset && !halt_q;

  // State sequencing, instruction field latch, halt/illegal flags.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur       <= S_IF;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= '0;
      funct_q   <= '0;
    end else if (!halt_q) begin
      case (cur)
        S_IF: begin
          op_q    <= op;
          funct_q <= funct;
          cur     <= S_ID;
        end
        S_ID: begin
          case (iclass)
            C_J, C_JAL, C_JR:     cur <= S_IF;
            C_BEQ, C_BNE, C_BLTZ: cur <= S_EXE_BR;
            C_LW, C_SW:           cur <= S_EXE_LS;
            C_ALU_R, C_ALU_I:     cur <= S_EXE_AL;
            C_HALT:               halt_q <= 1'b1;
            default: begin
              illegal_q <= 1'b1;
              halt_q    <= 1'b1;
            end
          endcase
        end
        S_EXE_AL: cur <= S_WB_AL;
        S_EXE_LS: cur <= S_MEM;
        S_MEM: begin
          if (mem_done) cur <= (iclass == C_LW) ? S_WB_LD : S_IF;
        end
        S_WB_AL, S_EXE_BR, S_WB_LD: cur <= S_IF;
        default: cur <= S_IF;
      endcase
    end
  end

  // Strobes and next-PC select; gated by Reset so they drop asynchronously.
  always_comb begin
    IRWre  = run && (cur == S_IF);
    PCWre  = 1'b0;
    RegWre = 1'b0;
    mRD    = 1'b0;
    mWR    = 1'b0;
    PCSrc  = PC_NEXT;
    if (run) begin
      case (cur)
        S_ID: begin
          case (iclass)
            C_J: begin
              PCWre = 1'b1;
              PCSrc = PC_JUMP;
            end
            C_JAL: begin
              PCWre  = 1'b1;
              PCSrc  = PC_JUMP;
              RegWre = 1'b1;
            end
            C_JR: begin
              PCWre = 1'b1;
              PCSrc = PC_RS;
            end
            default: ;
          endcase
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          if (branch_taken(iclass, zero, sign)) PCSrc = PC_BRANCH;
        end
        S_MEM: begin
          mRD   = (iclass == C_LW);
          mWR   = (iclass == C_SW);
          PCWre = mem_done && (iclass == C_SW);
        end
        S_WB_LD, S_WB_AL: begin
          PCWre  = 1'b1;
          RegWre = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = cur;
  assign halted  = halt_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// Scoreboard bench for the multi-cycle control unit: the driver pushes the
// expected completion record of each instruction, the monitor pops it on PCWre.
module tb_multi_cycle_ctrl_fsm;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWre, IRWre, RegWre, ExtSel, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] RegDst;
  logic       WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [1:0] PCSrc;
  logic [2:0] state;
  logic       halted, illegal;

  multi_cycle_ctrl_fsm dut (
    .CLK(CLK), .Reset(Reset), .op(op), .funct(funct), .zero(zero), .sign(sign),
    .mem_ready(mem_ready), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD),
    .mWR(mWR), .PCSrc(PCSrc), .state(state), .halted(halted), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef enum int {
    M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL, M_JR, M_ADDIU, M_ANDI, M_ORI,
    M_XORI, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE, M_BLTZ, M_J, M_JAL
  } mn_t;

  typedef struct {
    string name;
    int    cycles;
    int    st;
    int    pcsrc;
    int    regw;
    int    nrd;
    int    nwr;
    int    regdst;
    int    wrsrc;
    int    dbsrc;
    bit    chk_alu;
    int    aluop;
    int    ext;
    int    srca;
    int    srcb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic enc(input mn_t m, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    case (m)
      M_ADD:   begin o = 6'b000000; f = 6'b100000; end
      M_SUB:   begin o = 6'b000000; f = 6'b100010; end
      M_AND:   begin o = 6'b000000; f = 6'b100100; end
      M_OR:    begin o = 6'b000000; f = 6'b100101; end
      M_SLT:   begin o = 6'b000000; f = 6'b101010; end
      M_SLL:   begin o = 6'b000000; f = 6'b000000; end
      M_JR:    begin o = 6'b000000; f = 6'b001000; end
      M_ADDIU: o = 6'b001001;
      M_ANDI:  o = 6'b001100;
      M_ORI:   o = 6'b001101;
      M_XORI:  o = 6'b001110;
      M_SLTI:  o = 6'b001010;
      M_LW:    o = 6'b100011;
      M_SW:    o = 6'b101011;
      M_BEQ:   o = 6'b000100;
      M_BNE:   o = 6'b000101;
      M_BLTZ:  o = 6'b000001;
      M_J:     o = 6'b000010;
      default: o = 6'b000011;
    endcase
  endtask

  // Reference: what the instruction must look like on its PC-update cycle.
  function automatic exp_t model(input mn_t m, input int w, input bit z, input bit s);
    exp_t e;
    e.name = m.name();
    e.pcsrc = 0; e.regw = 0; e.nrd = 0; e.nwr = 0; e.regdst = 0;
    e.wrsrc = 0; e.dbsrc = 0; e.chk_alu = 1; e.aluop = 0; e.ext = 1;
    e.srca = 0; e.srcb = 0; e.cycles = 0; e.st = 0;
    case (m)
      M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL: begin
        e.cycles = 4; e.st = 7; e.regw = 1; e.regdst = 1;
        e.srca = (m == M_SLL) ? 1 : 0;
        e.aluop = (m == M_ADD) ? 0 : (m == M_SUB) ? 1 : (m == M_AND) ? 4 :
                  (m == M_OR) ? 3 : (m == M_SLT) ? 5 : 2;
      end
      M_ADDIU, M_ANDI, M_ORI, M_XORI, M_SLTI: begin
        e.cycles = 4; e.st = 7; e.regw = 1; e.srcb = 1;
        e.ext = (m == M_ANDI || m == M_ORI || m == M_XORI) ? 0 : 1;
        e.aluop = (m == M_ADDIU) ? 0 : (m == M_ANDI) ? 4 : (m == M_ORI) ? 3 :
                  (m == M_XORI) ? 6 : 5;
      end
      M_LW: begin
        e.cycles = 5 + w; e.st = 4; e.regw = 1; e.nrd = w + 1; e.dbsrc = 1; e.srcb = 1;
      end
      M_SW: begin
        e.cycles = 4 + w; e.st = 3; e.nwr = w + 1; e.srcb = 1;
      end
      M_BEQ, M_BNE, M_BLTZ: begin
        e.cycles = 3; e.st = 5; e.aluop = 1;
        if ((m == M_BEQ && z) || (m == M_BNE && !z) || (m == M_BLTZ && s)) e.pcsrc = 1;
      end
      M_J:  begin e.cycles = 2; e.st = 1; e.pcsrc = 3; e.chk_alu = 0; end
      M_JR: begin e.cycles = 2; e.st = 1; e.pcsrc = 2; e.chk_alu = 0; end
      default: begin
        e.cycles = 2; e.st = 1; e.pcsrc = 3; e.chk_alu = 0;
        e.regw = 1; e.regdst = 2; e.wrsrc = 1;
      end
    endcase
    return e;
  endfunction

  // Monitor: per-instruction counters, compared when PCWre appears.
  initial begin : monitor
    int   cyc, nrd, nwr, nrw;
    exp_t e;
    cyc = 0; nrd = 0; nwr = 0; nrw = 0;
    forever begin
      @(negedge CLK);
      if (!Reset) begin
        cyc = 0; nrd = 0; nwr = 0; nrw = 0;
        continue;
      end
      if (IRWre) begin
        cyc = 0; nrd = 0; nwr = 0; nrw = 0;
      end
      cyc++;
      nrd += int'(mRD);
      nwr += int'(mWR);
      nrw += int'(RegWre);
      if (PCWre) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pcwre: got PCWre=1 in state %0d, expected no completion", state);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_cycles"}, 32'(cyc), 32'(e.cycles));
          chk({e.name, "_state"}, 32'(state), 32'(e.st));
          chk({e.name, "_pcsrc"}, 32'(PCSrc), 32'(e.pcsrc));
          chk({e.name, "_regwre_cnt"}, 32'(nrw), 32'(e.regw));
          chk({e.name, "_mrd_cnt"}, 32'(nrd), 32'(e.nrd));
          chk({e.name, "_mwr_cnt"}, 32'(nwr), 32'(e.nwr));
          if (e.regw != 0) begin
            chk({e.name, "_regdst"}, 32'(RegDst), 32'(e.regdst));
            chk({e.name, "_wrregdsrc"}, 32'(WrRegDSrc), 32'(e.wrsrc));
            chk({e.name, "_dbdatasrc"}, 32'(DBDataSrc), 32'(e.dbsrc));
          end
          if (e.chk_alu) begin
            chk({e.name, "_aluop"}, 32'(ALUOp), 32'(e.aluop));
            chk({e.name, "_extsel"}, 32'(ExtSel), 32'(e.ext));
            chk({e.name, "_alusrca"}, 32'(ALUSrcA), 32'(e.srca));
            chk({e.name, "_alusrcb"}, 32'(ALUSrcB), 32'(e.srcb));
          end
        end
      end
    end
  end

  // Driver: called at posedge+1 of an IF cycle; returns at posedge+1 of the next IF.
  task automatic run_instr(input mn_t m, input int w, input bit z, input bit s);
    logic [5:0] o, f;
    int mcnt, budget;
    bit done;
    mcnt = 0; budget = 0; done = 1'b0;
    enc(m, o, f);
    sb.push_back(model(m, w, z, s));
    op = o; funct = f; zero = z; sign = s;
    mem_ready = 1'($urandom_range(0, 1));
    while (!done) begin
      @(negedge CLK);
      if (PCWre) begin
        done = 1'b1;
      end else begin
        budget++;
        if (budget > 40) begin
          checks++;
          errors++;
          $display("FAIL %s_timeout: got no PCWre in 40 cycles, expected completion", m.name());
          done = 1'b1;
        end
        @(posedge CLK); #1;
        if (state == 3'b011) begin
          mem_ready = (mcnt >= w);
          mcnt++;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic finish_summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got no end of test, expected finish");
    finish_summary();
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_irwre", 32'(IRWre), 32'd0);
    chk("reset_pcwre", 32'(PCWre), 32'd0);
    Reset = 1'b1;
    #1;
    chk("release_state_if", 32'(state), 32'd0);
    chk("release_irwre", 32'(IRWre), 32'd1);

    run_instr(M_ADD, 0, 1'b0, 1'b0);
    run_instr(M_LW, 3, 1'b0, 1'b0);
    run_instr(M_BEQ, 0, 1'b1, 1'b0);
    run_instr(M_BNE, 0, 1'b1, 1'b0);
    run_instr(M_JAL, 0, 1'b0, 1'b0);
    run_instr(M_SW, 0, 1'b0, 1'b0);
    run_instr(M_BLTZ, 0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      run_instr(mn_t'($urandom_range(0, 18)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    // Reset asserted in the middle of a stalled sw access.
    op = 6'b101011; funct = 6'b0; mem_ready = 1'b0;
    n = 0;
    while (state != 3'b011 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("sw_mwr_in_mem", 32'(mWR), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("sw_reset_mwr_async", 32'(mWR), 32'd0);
    chk("sw_reset_state_async", 32'(state), 32'd0);
    chk("sw_reset_pcwre", 32'(PCWre), 32'd0);
    chk("sw_reset_irwre", 32'(IRWre), 32'd0);

    // HALT opcode.
    op = 6'b111111;
    @(posedge CLK); #1;
    Reset = 1'b1;
    #1;
    chk("halt_release_state_if", 32'(state), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_state_out", 32'(state), 32'd1);
    chk("halt_illegal", 32'(illegal), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n += int'(PCWre) + int'(IRWre);
    end
    chk("halt_strobes_10cyc", 32'(n), 32'd0);
    chk("halt_still_halted", 32'(halted), 32'd1);

    // Unknown opcode, then unknown R-type funct.
    @(posedge CLK); #1;
    Reset = 1'b0;
    #1;
    chk("halt_cleared_by_reset", 32'(halted), 32'd0);
    op = 6'b110011;
    @(posedge CLK); #1;
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("illop_illegal", 32'(illegal), 32'd1);
    chk("illop_halted", 32'(halted), 32'd1);
    Reset = 1'b0;
    #1;
    chk("illegal_cleared_by_reset", 32'(illegal), 32'd0);
    op = 6'b000000; funct = 6'b111111;
    @(posedge CLK); #1;
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("illfn_illegal", 32'(illegal), 32'd1);
    chk("illfn_halted", 32'(halted), 32'd1);

    finish_summary();
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl_fsm.md
Name: multi_cycle_ctrl_fsm

Overview:
- True five-phase multi-cycle control unit for the MIPS-subset CPU. Phases are IF, ID, EXE, MEM, WB.
- Replaces the flat opcode decoder. It sequences each instruction through a state machine and issues per-state datapath strobes (PC, IR, register file, data memory).
- It latches the opcode and funct fields at the end of IF.
- It adds data-memory wait-state handshaking, a halt state and illegal-opcode trapping, none of which the flat decoder has.

Parameters:
- OPW, 6, opcode field width.
- FNW, 6, funct field width.
- MEM_WAIT_EN, 1. When 1, the MEM state waits on mem_ready. When 0, mem_ready is ignored and MEM always lasts one cycle.
- HALT_OP, 6'b111111, opcode that enters HALT.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- op  in  OPW  Instruction[31:26], sampled at the end of IF.
- funct  in  FNW  Instruction[5:0], sampled at the end of IF.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result[31].
- mem_ready  in  1  data memory access complete.
- PCWre  out  1  PC load strobe.
- IRWre  out  1  instruction register load.
- RegWre  out  1  register file write.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- ALUSrcA  out  1  1 = shamt.
- ALUSrcB  out  1  1 = immediate.
- ALUOp  out  3  ALU operation.
- RegDst  out  2  write register select: 00 rt, 01 rd, 10 $31.
- WrRegDSrc  out  1  1 = write PC+4 (jal).
- DBDataSrc  out  1  1 = memory data.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- PCSrc  out  2  next-PC select: 00 PC+4, 01 branch, 10 rs, 11 jump.
- state  out  3  current state, for debug.
- halted  out  1  HALT reached.
- illegal  out  1  sticky unknown-opcode flag.

Behaviour:
- State encoding:
  - IF 000
  - ID 001
  - EXE_LS 010
  - MEM 011
  - WB_LD 100
  - EXE_BR 101
  - EXE_AL 110
  - WB_AL 111
  - HALT is a separate flag state, with state output held at 001.
- Reset:
  - While Reset is low, state is forced to IF asynchronously and halted, illegal and the latched op/funct are cleared to 0.
  - All strobes (PCWre, IRWre, RegWre, mRD, mWR) are forced to 0 while Reset is low, including when Reset is asserted mid-instruction.
  - The first cycle after release is IF.
- Transitions:
  - IF goes to ID.
  - From ID:
    - j, jal, jr: back to IF.
    - beq, bne, bltz: EXE_BR.
    - lw, sw: EXE_LS.
    - R-type or immediate ALU ops: EXE_AL.
    - HALT_OP: HALT.
    - Unknown opcode: set illegal, then HALT.
  - EXE_AL goes to WB_AL, then IF.
  - EXE_BR goes to IF.
  - EXE_LS goes to MEM.
  - MEM:
    - Stays in MEM while MEM_WAIT_EN is set and mem_ready is 0.
    - When leaving: sw goes to IF, lw goes to WB_LD.
  - WB_LD goes to IF.
  - HALT is exited only by reset.
- Strobes:
  - IRWre is 1 only in IF.
  - PCWre is 1 for exactly one cycle, in the terminal state of each instruction: ID for jumps, EXE_BR, WB_AL, WB_LD, and the final MEM cycle for sw. PCWre is never 1 in HALT.
  - RegWre is 1 in WB_AL, in WB_LD, and in ID for jal (RegDst=10, WrRegDSrc=1).
  - mRD and mWR are held for every cycle spent in MEM, for lw and sw respectively.
- PCSrc, valid whenever PCWre=1:
  - 11 for j and jal.
  - 10 for jr.
  - 01 in EXE_BR when the branch is taken: beq and zero, bne and not zero, bltz and sign.
  - 00 otherwise.
- ALUOp:
  - Encoding: 000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt (signed), 110 xor, 111 pass B.
  - Branches use sub.
  - lw, sw and addiu use add.
- ExtSel is 0 for andi, ori and xori, and 1 otherwise.
- Supported decode:
  - R-type (op 000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - addiu 001001, andi 001100, ori 001101, xori 001110, slti 001010.
  - lw 100011, sw 101011.
  - beq 000100, bne 000101, bltz 000001.
  - j 000010, jal 000011.
  - An R-type with an unknown funct is illegal.
- Datapath outputs are Moore-decoded from state plus latched op/funct. PCSrc in EXE_BR additionally depends on zero and sign (same cycle).

Decomposition:
- Shared package mcpu_pkg holds:
  - the state encoding constants;
  - opcode and funct localparams;
  - the ALUOp and PCSrc codes.
- One sub-module, mcpu_decode: combinational op/funct to instruction-class and ALUOp/ExtSel decode.
- The FSM and strobe generation stay in the top of the block.

Test Plan:
- add (op 000000, funct 100000) after reset release:
  - states go IF, ID, EXE_AL, WB_AL, IF;
  - RegWre=1 and RegDst=01 only in WB_AL;
  - PCWre=1 only in WB_AL with PCSrc=00.
- lw, with mem_ready held low for 3 cycles and MEM_WAIT_EN=1:
  - 4 MEM cycles, with mRD=1 throughout;
  - then WB_LD with RegWre=1 and DBDataSrc=1;
  - total 8 cycles.
- beq:
  - zero=1 in EXE_BR gives PCSrc=01 and PCWre=1;
  - a bne with zero=1 gives PCSrc=00.
- jal:
  - completes in ID with PCWre=1, PCSrc=11, RegWre=1, RegDst=10 and WrRegDSrc=1;
  - the next state is IF.
- Reset low mid-MEM of sw:
  - mWR drops to 0 immediately, without waiting for a clock edge;
  - after release, state=IF.
- Halt and illegal opcodes:
  - op 111111 gives halted=1 and PCWre stuck at 0 for 10 cycles;
  - op 110011 gives illegal=1 and halted=1.
